// File: rtl/exec_pkg.sv
// Shared definitions for the execute units: opcodes, branch conditions, ALU ops,
// exception numbers and the control-flow unit state encoding.
package exec_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] COND_BEQ  = 3'd0;
    localparam logic [2:0] COND_BNE  = 3'd1;
    localparam logic [2:0] COND_BLT  = 3'd4;
    localparam logic [2:0] COND_BGE  = 3'd5;
    localparam logic [2:0] COND_BLTU = 3'd6;
    localparam logic [2:0] COND_BGEU = 3'd7;

    localparam logic [5:0] EXC_INSN_MISALIGNED = 6'd0;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_SLT  = 5'd2,
        ALU_SLTU = 5'd3
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_CHECK,
        ST_TARGET,
        ST_LINK
    } cf_state_t;

    function automatic alu_op_t branch_alu_op(input logic [2:0] funct3);
        case (funct3)
            COND_BLT, COND_BGE:   return ALU_SLT;
            COND_BLTU, COND_BGEU: return ALU_SLTU;
            default:              return ALU_SUB;
        endcase
    endfunction

    function automatic logic branch_known(input logic [2:0] funct3);
        return (funct3 != 3'd2) && (funct3 != 3'd3);
    endfunction

endpackage

// File: rtl/cf_cond_eval.sv
// Branch condition evaluation: funct3 plus ALU compare flags -> take.
module cf_cond_eval
    import exec_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       eq,
    input  logic       lt,
    input  logic       ltu,
    output logic       take
);

    always_comb begin
        take = 1'b0;
        case (funct3)
            COND_BEQ:  take = eq;
            COND_BNE:  take = !eq;
            COND_BLT:  take = lt;
            COND_BGE:  take = !lt;
            COND_BLTU: take = ltu;
            COND_BGEU: take = !ltu;
            default:   take = 1'b0;
        endcase
    end

endmodule

// File: rtl/execute_control_flow.sv
// Multi-cycle control-flow execute unit (BRANCH/JAL/JALR) sharing the ALU.
// Optional CF_PREDICT_EN adds pred_taken; jump_pc_out then flags mispredicts only.
module execute_control_flow
    import exec_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned LINK_INC = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic [6:0]      decode_opcode,
    input  logic [2:0]      decode_funct3,
    input  logic [XLEN-1:0] decode_imm,
    input  logic [XLEN-1:0] decode_pc,
    input  logic [XLEN-1:0] read_rs1_val,
    input  logic [XLEN-1:0] read_rs2_val,
    input  logic            read_valid,
`ifdef CF_PREDICT_EN
    input  logic            pred_taken,
`endif
    output logic [XLEN:0]   in_a,
    output logic [XLEN:0]   in_b,
    output logic [4:0]      alu_op,
    output logic            alu_valid,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_lt,
    input  logic            alu_ltu,
    input  logic            alu_eq,
    output logic            processing,
    output logic            valid,
    output logic [XLEN-1:0] pc_out,
    output logic            jump_pc_out,
    output logic [XLEN-1:0] rd_val_out,
    output logic            rd_write_out,
    output logic [5:0]      exception_num_out,
    output logic            exception_valid_out
);

    cf_state_t       state, state_next;
    logic [XLEN-1:0] target_q, target_d;
    logic            is_branch, is_jal, is_jalr, known, take, pred;
    logic [XLEN-1:0] tgt;
    alu_op_t         op;

`ifdef CF_PREDICT_EN
    assign pred = pred_taken;
`else
    assign pred = 1'b0;
`endif

    assign is_branch = (decode_opcode == OPC_BRANCH) && branch_known(decode_funct3);
    assign is_jal    = (decode_opcode == OPC_JAL);
    assign is_jalr   = (decode_opcode == OPC_JALR) && (decode_funct3 == 3'd0);
    assign known     = is_branch || is_jal || is_jalr;
    assign tgt       = {alu_result[XLEN-1:1], alu_result[0] & !is_jalr};

    assign alu_op            = op;
    assign alu_valid         = processing;
    assign exception_num_out = EXC_INSN_MISALIGNED;

    cf_cond_eval u_cond (
        .funct3 (decode_funct3),
        .eq     (alu_eq),
        .lt     (alu_lt),
        .ltu    (alu_ltu),
        .take   (take)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_CHECK;
            target_q <= '0;
        end else begin
            state    <= state_next;
            target_q <= target_d;
        end
    end

    always_comb begin
        state_next = state;
        target_d   = target_q;
        case (state)
            ST_CHECK: begin
                if (read_valid && known) begin
                    if (is_branch) begin
                        if (take)      state_next = ST_TARGET;
                        else if (pred) state_next = ST_LINK;
                    end else if (tgt[1:0] == 2'b00) begin
                        state_next = ST_LINK;
                        target_d   = tgt;
                    end
                end
            end
            ST_TARGET, ST_LINK: state_next = ST_CHECK;
            default:            state_next = ST_CHECK;
        endcase
        if (flush) begin
            state_next = ST_CHECK;
            target_d   = '0;
        end
    end

    always_comb begin
        processing          = 1'b0;
        valid               = 1'b0;
        jump_pc_out         = 1'b0;
        rd_write_out        = 1'b0;
        exception_valid_out = 1'b0;
        in_a                = '0;
        in_b                = '0;
        op                  = ALU_ADD;
        pc_out              = '0;
        rd_val_out          = '0;
        if (!reset) begin
            case (state)
                ST_CHECK: begin
                    if (read_valid && known) begin
                        processing = 1'b1;
                        if (is_branch) begin
                            in_a = {1'b0, read_rs1_val};
                            in_b = {1'b0, read_rs2_val};
                            op   = branch_alu_op(decode_funct3);
                            valid = !take && !pred;
                        end else begin
                            in_a = {1'b0, (is_jal ? decode_pc : read_rs1_val)};
                            in_b = {1'b0, decode_imm};
                            if (tgt[1:0] != 2'b00) begin
                                valid               = 1'b1;
                                exception_valid_out = 1'b1;
                                pc_out              = tgt;
                            end
                        end
                    end
                end
                ST_TARGET: begin
                    processing          = 1'b1;
                    in_a                = {1'b0, decode_pc};
                    in_b                = {1'b0, decode_imm};
                    pc_out              = alu_result;
                    valid               = 1'b1;
                    exception_valid_out = (alu_result[1:0] != 2'b00);
                    jump_pc_out         = (alu_result[1:0] == 2'b00) && !pred;
                end
                ST_LINK: begin
                    processing  = 1'b1;
                    in_a        = {1'b0, decode_pc};
                    in_b        = {1'b0, XLEN'(LINK_INC)};
                    valid       = 1'b1;
                    jump_pc_out = 1'b1;
                    // A branch only lands here as a mispredicted fall-through: redirect, no link write.
                    if (is_branch) begin
                        pc_out = alu_result;
                    end else begin
                        pc_out       = target_q;
                        rd_write_out = 1'b1;
                        rd_val_out   = alu_result;
                    end
                end
                default: ;
            endcase
            if (flush) begin
                valid               = 1'b0;
                jump_pc_out         = 1'b0;
                rd_write_out        = 1'b0;
                exception_valid_out = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_execute_control_flow.sv
// Self-checking bench for execute_control_flow: behavioural ALU, directed cases and
// randomized instructions checked against a per-instruction outcome model.
module tb_execute_control_flow;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset, flush, read_valid, pred;
    logic [6:0]      decode_opcode;
    logic [2:0]      decode_funct3;
    logic [XLEN-1:0] decode_imm, decode_pc, read_rs1_val, read_rs2_val;
    logic [XLEN:0]   in_a, in_b;
    logic [4:0]      alu_op;
    logic            alu_valid;
    logic [XLEN-1:0] alu_result;
    logic            alu_lt, alu_ltu, alu_eq;
    logic            processing, valid, jump_pc_out, rd_write_out, exception_valid_out;
    logic [XLEN-1:0] pc_out, rd_val_out;
    logic [5:0]      exception_num_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    execute_control_flow #(.XLEN(XLEN), .LINK_INC(4)) dut (
        .clk                 (clk),
        .reset               (reset),
        .flush               (flush),
        .decode_opcode       (decode_opcode),
        .decode_funct3       (decode_funct3),
        .decode_imm          (decode_imm),
        .decode_pc           (decode_pc),
        .read_rs1_val        (read_rs1_val),
        .read_rs2_val        (read_rs2_val),
        .read_valid          (read_valid),
`ifdef CF_PREDICT_EN
        .pred_taken          (pred),
`endif
        .in_a                (in_a),
        .in_b                (in_b),
        .alu_op              (alu_op),
        .alu_valid           (alu_valid),
        .alu_result          (alu_result),
        .alu_lt              (alu_lt),
        .alu_ltu             (alu_ltu),
        .alu_eq              (alu_eq),
        .processing          (processing),
        .valid               (valid),
        .pc_out              (pc_out),
        .jump_pc_out         (jump_pc_out),
        .rd_val_out          (rd_val_out),
        .rd_write_out        (rd_write_out),
        .exception_num_out   (exception_num_out),
        .exception_valid_out (exception_valid_out)
    );

    // Shared ALU stand-in: same-cycle result and compare flags.
    logic [XLEN-1:0] opa, opb;
    assign opa = in_a[XLEN-1:0];
    assign opb = in_b[XLEN-1:0];
    always_comb begin
        alu_result = (alu_op == 5'd1) ? opa - opb : opa + opb;
        alu_eq     = (opa == opb);
        alu_lt     = ($signed(opa) < $signed(opb));
        alu_ltu    = (opa < opb);
    end

    typedef struct {
        bit          known;
        int          lat;
        bit          jump;
        bit          exc;
        bit          rdw;
        logic [31:0] pc;
        logic [31:0] rd;
    } exp_t;

    // Architectural outcome of one instruction, derived from the ISA rules.
    function automatic exp_t model(input logic [6:0] opc, input logic [2:0] f3,
                                   input logic [31:0] rs1, input logic [31:0] rs2,
                                   input logic [31:0] imm, input logic [31:0] pc,
                                   input bit p);
        exp_t e;
        bit t;
        logic [31:0] dest;
        e = '{default: 0};
        if (opc == 7'h63 && f3 != 3'd2 && f3 != 3'd3) begin
            e.known = 1;
            case (f3)
                3'd0:    t = (rs1 == rs2);
                3'd1:    t = (rs1 != rs2);
                3'd4:    t = ($signed(rs1) < $signed(rs2));
                3'd5:    t = ($signed(rs1) >= $signed(rs2));
                3'd6:    t = (rs1 < rs2);
                default: t = (rs1 >= rs2);
            endcase
            if (t) begin
                e.lat  = 2;
                e.pc   = pc + imm;
                e.exc  = (e.pc % 4) != 0;
                e.jump = !e.exc && !p;
            end else if (p) begin
                e.lat  = 2;
                e.pc   = pc + 4;
                e.jump = 1;
            end else begin
                e.lat = 1;
            end
        end else if (opc == 7'h6f || (opc == 7'h67 && f3 == 3'd0)) begin
            e.known = 1;
            dest = (opc == 7'h6f) ? pc + imm : ((rs1 + imm) & ~32'd1);
            if ((dest % 4) != 0) begin
                e.lat = 1;
                e.exc = 1;
            end else begin
                e.lat  = 2;
                e.pc   = dest;
                e.jump = 1;
                e.rdw  = 1;
                e.rd   = pc + 4;
            end
        end
        return e;
    endfunction

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] imm, input logic [31:0] pc,
                         input bit p);
        decode_opcode = opc;
        decode_funct3 = f3;
        read_rs1_val  = rs1;
        read_rs2_val  = rs2;
        decode_imm    = imm;
        decode_pc     = pc;
        pred          = p;
        read_valid    = 1'b1;
    endtask

    task automatic idle();
        read_valid = 1'b0;
        flush      = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        drive(7'h6f, 3'd0, 32'h0, 32'h0, 32'h10, 32'h500, 1'b0);
        reset = 1'b1;
        #1;
        checks++; if (processing !== 1'b0) begin errors++; $display("FAIL rst_processing got=%0b want=0", processing); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0b want=0", valid); end
        checks++; if (in_a !== 33'h0) begin errors++; $display("FAIL rst_in_a got=%h want=0", in_a); end
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL rst_pc_out got=%h want=0", pc_out); end
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL rst_alu_valid got=%0b want=0", alu_valid); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (processing !== 1'b1) begin errors++; $display("FAIL rst_start got=%0b want=1", processing); end
        @(negedge clk);
        reset = 1'b1;
        read_valid = 1'b0;
        #1;
        checks++; if (valid !== 1'b0 || rd_write_out !== 1'b0) begin errors++; $display("FAIL rst_in_link valid=%0b rd_write=%0b want=0,0", valid, rd_write_out); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (processing !== 1'b0) begin errors++; $display("FAIL rst_back_to_check got=%0b want=0", processing); end
        idle();
    endtask

    task automatic test_branch();
        drive(7'h63, 3'd0, 32'd5, 32'd5, 32'h20, 32'h100, 1'b0);
        #1;
        checks++; if (alu_op !== 5'd1 || valid !== 1'b0 || alu_valid !== 1'b1) begin errors++; $display("FAIL beq_c0 op=%0d valid=%0b alu_valid=%0b want=1,0,1", alu_op, valid, alu_valid); end
        @(negedge clk); #1;
        checks++; if (alu_op !== 5'd0 || in_a !== 33'h100) begin errors++; $display("FAIL beq_c1_alu op=%0d a=%h want=0,100", alu_op, in_a); end
        checks++; if (valid !== 1'b1 || jump_pc_out !== 1'b1 || pc_out !== 32'h120) begin errors++; $display("FAIL beq_c1 valid=%0b jump=%0b pc=%h want=1,1,120", valid, jump_pc_out, pc_out); end
        @(negedge clk);
        drive(7'h63, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h8, 32'h200, 1'b0);
        #1;
        checks++; if (alu_op !== 5'd2 || valid !== 1'b0) begin errors++; $display("FAIL blt_c0 op=%0d valid=%0b want=2,0", alu_op, valid); end
        @(negedge clk); #1;
        checks++; if (valid !== 1'b1 || jump_pc_out !== 1'b1 || pc_out !== 32'h208) begin errors++; $display("FAIL blt_c1 valid=%0b jump=%0b pc=%h want=1,1,208", valid, jump_pc_out, pc_out); end
        @(negedge clk);
        drive(7'h63, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h8, 32'h200, 1'b0);
        #1;
        checks++; if (alu_op !== 5'd3 || valid !== 1'b1 || jump_pc_out !== 1'b0) begin errors++; $display("FAIL bltu_nt op=%0d valid=%0b jump=%0b want=3,1,0", alu_op, valid, jump_pc_out); end
        idle();
    endtask

    task automatic test_jump();
        drive(7'h67, 3'd0, 32'h203, 32'h0, 32'h0, 32'h40, 1'b0);
        #1;
        checks++; if (valid !== 1'b1 || exception_valid_out !== 1'b1 || exception_num_out !== 6'd0) begin errors++; $display("FAIL jalr_mis valid=%0b exc=%0b num=%0d want=1,1,0", valid, exception_valid_out, exception_num_out); end
        checks++; if (jump_pc_out !== 1'b0 || rd_write_out !== 1'b0) begin errors++; $display("FAIL jalr_mis_side jump=%0b rd_write=%0b want=0,0", jump_pc_out, rd_write_out); end
        @(negedge clk);
        drive(7'h6f, 3'd0, 32'h0, 32'h0, 32'hFFFF_FFF8, 32'h1000, 1'b0);
        #1;
        checks++; if (valid !== 1'b0 || processing !== 1'b1) begin errors++; $display("FAIL jal_c0 valid=%0b proc=%0b want=0,1", valid, processing); end
        @(negedge clk); #1;
        checks++; if (pc_out !== 32'hFF8 || jump_pc_out !== 1'b1) begin errors++; $display("FAIL jal_c1_pc pc=%h jump=%0b want=ff8,1", pc_out, jump_pc_out); end
        checks++; if (rd_val_out !== 32'h1004 || rd_write_out !== 1'b1 || valid !== 1'b1) begin errors++; $display("FAIL jal_c1_rd rd=%h wr=%0b valid=%0b want=1004,1,1", rd_val_out, rd_write_out, valid); end
        @(negedge clk);
        drive(7'h67, 3'd0, 32'h301, 32'h0, 32'h10, 32'h80, 1'b0);
        @(negedge clk); #1;
        checks++; if (pc_out !== 32'h310 || rd_val_out !== 32'h84) begin errors++; $display("FAIL jalr_bit0 pc=%h rd=%h want=310,84", pc_out, rd_val_out); end
        @(negedge clk);
        drive(7'h67, 3'd1, 32'h300, 32'h0, 32'h10, 32'h80, 1'b0);
        #1;
        checks++; if (processing !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL bad_funct3 proc=%0b valid=%0b want=0,0", processing, valid); end
        idle();
    endtask

    task automatic test_flush();
        drive(7'h63, 3'd5, 32'd5, 32'd3, 32'h10, 32'h200, 1'b0);
        #1;
        checks++; if (processing !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL bge_c0 proc=%0b valid=%0b want=1,0", processing, valid); end
        @(negedge clk);
        flush = 1'b1;
        #1;
        checks++; if (valid !== 1'b0 || jump_pc_out !== 1'b0) begin errors++; $display("FAIL flush_target valid=%0b jump=%0b want=0,0", valid, jump_pc_out); end
        @(negedge clk);
        flush = 1'b0;
        drive(7'h6f, 3'd0, 32'h0, 32'h0, 32'h40, 32'h300, 1'b0);
        #1;
        checks++; if (processing !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL after_flush_c0 proc=%0b valid=%0b want=1,0", processing, valid); end
        @(negedge clk); #1;
        checks++; if (valid !== 1'b1 || pc_out !== 32'h340 || rd_val_out !== 32'h304) begin errors++; $display("FAIL after_flush_c1 valid=%0b pc=%h rd=%h want=1,340,304", valid, pc_out, rd_val_out); end
        idle();
    endtask

`ifdef CF_PREDICT_EN
    task automatic test_predict();
        drive(7'h63, 3'd1, 32'd7, 32'd7, 32'h40, 32'h80, 1'b1);
        #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL pred_nt_c0 valid=%0b want=0", valid); end
        @(negedge clk); #1;
        checks++; if (valid !== 1'b1 || pc_out !== 32'h84 || jump_pc_out !== 1'b1 || rd_write_out !== 1'b0) begin errors++; $display("FAIL pred_nt_c1 valid=%0b pc=%h jump=%0b wr=%0b want=1,84,1,0", valid, pc_out, jump_pc_out, rd_write_out); end
        @(negedge clk);
        drive(7'h63, 3'd1, 32'd7, 32'd7, 32'h40, 32'h80, 1'b0);
        #1;
        checks++; if (valid !== 1'b1 || jump_pc_out !== 1'b0) begin errors++; $display("FAIL nopred_nt valid=%0b jump=%0b want=1,0", valid, jump_pc_out); end
        @(negedge clk);
        drive(7'h63, 3'd0, 32'd7, 32'd7, 32'h40, 32'h80, 1'b1);
        @(negedge clk); #1;
        checks++; if (valid !== 1'b1 || jump_pc_out !== 1'b0 || pc_out !== 32'hC0) begin errors++; $display("FAIL pred_t valid=%0b jump=%0b pc=%h want=1,0,c0", valid, jump_pc_out, pc_out); end
        idle();
    endtask
`endif

    task automatic run_random(input int count, input bit gaps, input string tag);
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [31:0] rs1, rs2, imm, pc, r;
        bit          p;
        exp_t        e;
        for (int n = 0; n < count; n++) begin
            r = $urandom;
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: begin opc = 7'h63; f3 = 3'($urandom_range(0, 7)); end
                6, 7:             begin opc = 7'h6f; f3 = 3'($urandom_range(0, 7)); end
                8:                begin opc = 7'h67; f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0; end
                default:          begin opc = 7'h33; f3 = 3'($urandom_range(0, 7)); end
            endcase
            rs1 = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 8)) - 32'd4;
            rs2 = ($urandom_range(0, 2) == 0) ? rs1 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 8)) - 32'd4);
            imm = {{20{r[11]}}, r[11:0]};
            if ($urandom_range(0, 1) == 1) imm[1:0] = 2'b00;
            pc  = $urandom & 32'hFFFF_FFFC;
`ifdef CF_PREDICT_EN
            p = 1'($urandom_range(0, 1));
`else
            p = 1'b0;
`endif
            e = model(opc, f3, rs1, rs2, imm, pc, p);
            drive(opc, f3, rs1, rs2, imm, pc, p);
            #1;
            checks++; if (processing !== e.known) begin errors++; $display("FAIL %s_proc n=%0d got=%0b want=%0b", tag, n, processing, e.known); end
            checks++; if (valid !== 1'(e.known && e.lat == 1)) begin errors++; $display("FAIL %s_valid0 n=%0d got=%0b want=%0b", tag, n, valid, e.known && e.lat == 1); end
            if (e.lat == 2) begin
                @(negedge clk); #1;
                checks++; if (valid !== 1'b1) begin errors++; $display("FAIL %s_valid1 n=%0d got=%0b want=1", tag, n, valid); end
            end
            if (e.known) begin
                checks++; if (jump_pc_out !== e.jump) begin errors++; $display("FAIL %s_jump n=%0d got=%0b want=%0b", tag, n, jump_pc_out, e.jump); end
                checks++; if (exception_valid_out !== e.exc) begin errors++; $display("FAIL %s_exc n=%0d got=%0b want=%0b", tag, n, exception_valid_out, e.exc); end
                checks++; if (rd_write_out !== e.rdw) begin errors++; $display("FAIL %s_rdw n=%0d got=%0b want=%0b", tag, n, rd_write_out, e.rdw); end
                if (e.jump) begin
                    checks++; if (pc_out !== e.pc) begin errors++; $display("FAIL %s_pc n=%0d got=%h want=%h", tag, n, pc_out, e.pc); end
                end
                if (e.rdw) begin
                    checks++; if (rd_val_out !== e.rd) begin errors++; $display("FAIL %s_rd n=%0d got=%h want=%h", tag, n, rd_val_out, e.rd); end
                end
            end
            @(negedge clk);
            if (gaps) begin
                read_valid = 1'b0;
                #1;
                checks++; if (processing !== 1'b0) begin errors++; $display("FAIL %s_gap n=%0d got=%0b want=0", tag, n, processing); end
                @(negedge clk);
            end
        end
        idle();
    endtask

    task automatic test_random();
        run_random(150, 1'b1, "rand");
    endtask

    task automatic test_back_to_back();
        run_random(150, 1'b0, "b2b");
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        read_valid = 1'b0;
        pred = 1'b0;
        decode_opcode = '0;
        decode_funct3 = '0;
        decode_imm = '0;
        decode_pc = '0;
        read_rs1_val = '0;
        read_rs2_val = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_branch();
        test_jump();
        test_flush();
`ifdef CF_PREDICT_EN
        test_predict();
`endif
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
